// File: rtl/imem_readback_if.sv
// imem_readback_if: byte stream from the readback engine to the pad mux.
// The engine is the master; the consumer drives out_ready.
interface imem_readback_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/imem_readback.sv
// imem_readback: reads a block of instruction memory and streams it out
// behind a valid/ready handshake, keeping a running 8-bit checksum.
module imem_readback #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    imem_readback_if.master   out_if,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] maddr_q;
    logic [ADDR_W-1:0] maddr_nxt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_nxt;
    logic              xfer;

    // A byte leaves only while it is being presented in HOLD.
    assign xfer = (state == S_HOLD) & out_if.out_ready;

    // Next-state and datapath updates; abort beats a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        count_nxt = count;
        maddr_nxt = maddr_q;
        data_nxt  = data_q;
        sum_nxt   = sum_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    sum_nxt = '0;
                    if (length != '0) begin
                        addr_nxt  = base_addr;
                        count_nxt = length;
                        maddr_nxt = base_addr;
                        state_nxt = S_READ;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_nxt = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    data_nxt  = mem_rdata;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (xfer) begin
                    sum_nxt   = sum_q + data_q;
                    addr_nxt  = addr + 1'b1;
                    count_nxt = count - 1'b1;
                    if (count == LEN_W'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        maddr_nxt = addr + 1'b1;
                        state_nxt = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr    <= '0;
            count   <= '0;
            maddr_q <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            count   <= count_nxt;
            maddr_q <= maddr_nxt;
            data_q  <= data_nxt;
            sum_q   <= sum_nxt;
        end
    end

    assign mem_addr         = maddr_q;
    assign mem_re           = (state == S_READ);
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = (state == S_HOLD);
    assign busy             = (state == S_READ) |
                              (state == S_CAPTURE) |
                              (state == S_HOLD);
    assign done             = (state == S_DONE);
    assign checksum         = sum_q;

endmodule

// File: tb/tb_imem_readback.sv
// tb_imem_readback: randomized and directed readback transfers checked
// every cycle against a transaction-level model of the stream.
module tb_imem_readback;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] base_addr = '0;
    logic [7:0] length = '0;
    logic [6:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_rdata = '0;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    imem_readback_if #(.DATA_W(8)) s_if ();

    imem_readback #(
        .ADDR_W(7),
        .DATA_W(8),
        .LEN_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .length(length),
        .mem_addr(mem_addr),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .out_if(s_if),
        .busy(busy),
        .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [128];

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: one outstanding transfer described by address, bytes left,
    // whether its current byte has been read, and the running sum.
    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic       m_read = 1'b0;
    logic [6:0] m_addr = '0;
    int         m_rem = 0;
    logic [7:0] m_sum = '0;
    int         n_done = 0;
    logic [7:0] got_q[$];
    logic [6:0] addr_q[$];

    int         rdy_mode = 0;
    logic       rdy_val = 1'b0;

    initial begin
        s_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       s_if.out_ready = 1'b1;
                1:       s_if.out_ready = ($urandom_range(0, 3) != 0);
                default: s_if.out_ready = rdy_val;
            endcase
        end
    end

    initial begin
        logic nd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs",
                    {mem_addr, mem_re, s_if.out_data, s_if.out_valid,
                     busy, done, checksum}, '0);
                m_active = 1'b0;
                m_done   = 1'b0;
                m_read   = 1'b0;
                m_sum    = '0;
            end else begin
                chk("busy", busy, m_active);
                chk("done", done, m_done);
                chk("checksum", checksum, m_sum);
                if (done) n_done++;
                if (mem_re) begin
                    chk("re_legal", {m_active, m_read}, 2'b10);
                    chk("mem_addr", mem_addr, m_addr);
                    addr_q.push_back(mem_addr);
                    m_read = 1'b1;
                end
                if (s_if.out_valid) begin
                    chk("valid_legal", {m_active, m_read}, 2'b11);
                    chk("out_data", s_if.out_data, mem[m_addr]);
                end
                nd = 1'b0;
                if (!m_active) begin
                    if (start && !m_done) begin
                        m_sum = '0;
                        if (length == 0) begin
                            nd = 1'b1;
                        end else begin
                            m_active = 1'b1;
                            m_addr   = base_addr;
                            m_rem    = int'(length);
                            m_read   = 1'b0;
                        end
                    end
                end else if (abort) begin
                    m_active = 1'b0;
                end else if (s_if.out_valid && s_if.out_ready) begin
                    got_q.push_back(s_if.out_data);
                    m_sum  = m_sum + mem[m_addr];
                    m_addr = m_addr + 7'd1;
                    m_rem  = m_rem - 1;
                    m_read = 1'b0;
                    if (m_rem == 0) begin
                        m_active = 1'b0;
                        nd = 1'b1;
                    end
                end
                m_done = nd;
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [6:0] b, input logic [7:0] l);
        wait_edge();
        start     = 1'b1;
        base_addr = b;
        length    = l;
        wait_edge();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    initial begin
        int         lat_r;
        int         lat_v;
        int         snap;
        bit         found;
        logic [7:0] ref_sum;
        logic [7:0] held;
        logic [7:0] exp4 [4];
        logic [6:0] b;
        logic [7:0] l;

        exp4[0] = 8'h11;
        exp4[1] = 8'h22;
        exp4[2] = 8'h33;
        exp4[3] = 8'h44;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;
        mem[7'h12] = 8'h33;
        mem[7'h13] = 8'h44;
        mem[7'h7E] = 8'h01;
        mem[7'h7F] = 8'h02;
        mem[7'h00] = 8'h03;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_state",
            {mem_addr, mem_re, s_if.out_valid, busy, done, checksum}, '0);
        rst_n = 1'b1;

        // T1: basic four-byte block, latency and checksum
        rdy_mode = 0;
        got_q.delete();
        snap = n_done;
        wait_edge();
        start     = 1'b1;
        base_addr = 7'h10;
        length    = 8'd4;
        lat_r = -1;
        lat_v = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_re && lat_r < 0) lat_r = k;
            if (s_if.out_valid && lat_v < 0) lat_v = k;
            if (k == 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        chk("t1_re_latency", lat_r, 1);
        chk("t1_valid_latency", lat_v, 3);
        wait_done("t1_done", 40);
        wait_edge();
        chk("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk("t1_byte", got_q[i], exp4[i]);
        chk("t1_checksum", checksum, 8'hAA);
        chk("t1_done_once", n_done - snap, 1);

        // T2: address wrap 7E,7F,00
        got_q.delete();
        addr_q.delete();
        pulse_start(7'h7E, 8'd3);
        wait_done("t2_done", 40);
        wait_edge();
        chk("t2_addrs", {addr_q.size() == 3 ? 1'b1 : 1'b0}, 1'b1);
        if (addr_q.size() == 3)
            chk("t2_addr_seq", {addr_q[0], addr_q[1], addr_q[2]},
                {7'h7E, 7'h7F, 7'h00});
        chk("t2_checksum", checksum, 8'h06);

        // T3: consumer stalls five cycles in HOLD
        rdy_mode = 2;
        rdy_val  = 1'b0;
        got_q.delete();
        pulse_start(7'h10, 8'd2);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            wait_edge();
            if (s_if.out_valid) found = 1'b1;
        end
        chk("t3_valid_seen", found, 1'b1);
        held = s_if.out_data;
        chk("t3_first_byte", held, 8'h11);
        for (int k = 0; k < 5; k++) begin
            wait_edge();
            chk("t3_stall", {s_if.out_valid, s_if.out_data, mem_re},
                {1'b1, held, 1'b0});
        end
        rdy_val = 1'b1;
        wait_done("t3_done", 40);
        wait_edge();
        chk("t3_checksum", checksum, 8'h33);
        chk("t3_count", got_q.size(), 2);

        // T4: zero length goes straight to done
        rdy_mode = 0;
        wait_edge();
        start     = 1'b1;
        base_addr = 7'h20;
        length    = 8'd0;
        lat_v = -1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done && lat_v < 0) lat_v = k;
            if (k == 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        chk("t4_done_latency", {lat_v >= 1 && lat_v <= 2 ? 1'b1 : 1'b0}, 1'b1);
        chk("t4_checksum", checksum, 8'h00);

        // T5: abort while second byte is held
        got_q.delete();
        snap = n_done;
        pulse_start(7'h10, 8'd4);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            wait_edge();
            if (s_if.out_valid && got_q.size() == 1) found = 1'b1;
        end
        chk("t5_second_hold", found, 1'b1);
        abort = 1'b1;
        wait_edge();
        abort = 1'b0;
        chk("t5_after_abort", {busy, s_if.out_valid, checksum},
            {1'b0, 1'b0, 8'h11});
        repeat (4) wait_edge();
        chk("t5_no_done", n_done - snap, 0);
        pulse_start(7'h10, 8'd4);
        wait_done("t5_restart_done", 40);
        wait_edge();
        chk("t5_restart_sum", checksum, 8'hAA);

        // T6: reset mid-transfer with a start re-pulsed while busy
        rdy_mode = 1;
        pulse_start(7'h20, 8'd30);
        repeat (6) wait_edge();
        start     = 1'b1;
        base_addr = 7'h55;
        length    = 8'd3;
        wait_edge();
        start = 1'b0;
        repeat (3) wait_edge();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset",
            {mem_addr, mem_re, s_if.out_data, s_if.out_valid,
             busy, done, checksum}, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) wait_edge();
        chk("t6_quiet", {s_if.out_valid, busy, mem_re}, 3'b000);
        rdy_mode = 0;
        got_q.delete();
        ref_sum = '0;
        for (int i = 0; i < 5; i++) ref_sum = ref_sum + mem[7'h40 + i];
        pulse_start(7'h40, 8'd5);
        wait_done("t6_clean_done", 60);
        wait_edge();
        chk("t6_clean_sum", checksum, ref_sum);
        chk("t6_clean_count", got_q.size(), 5);

        // Random transfers with stalls, aborts and ignored starts
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            rdy_mode = int'($urandom_range(0, 1));
            b = 7'($urandom);
            l = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            pulse_start(b, l);
            for (int c = 0; c < 400; c++) begin
                if (!busy) break;
                abort     = ($urandom_range(0, 59) == 0);
                start     = ($urandom_range(0, 9) == 0);
                base_addr = 7'($urandom);
                length    = 8'($urandom_range(1, 5));
                wait_edge();
            end
            abort = 1'b0;
            start = 1'b0;
            chk("rnd_terminated", busy, 1'b0);
            wait_edge();
            wait_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
